// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: row-scanned, frame-debounced key matrix reader with a valid/ready key event output.
// Define KEYSCAN_SYNC_EN to pass the column lines through a 2-flop synchronizer before sampling.
module key_matrix_scanner #(
    parameter int ROWS     = 5,
    parameter int COLS     = 7,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 2,
    localparam int KW      = $clog2(ROWS * COLS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic [ROWS-1:0] L,
    input  logic [COLS-1:0] C,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    input  logic            key_ready,
    output logic            key_held
);
    localparam int N  = ROWS * COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, REPORT, HELD} state_t;

    logic [DW-1:0]   div;
    logic [RW-1:0]   row;
    logic [COLS-1:0] col;
    logic [N-1:0]    frame, full, prev, deb;
    logic [SW-1:0]   cnt, nxt_cnt;
    logic [KW-1:0]   low;
    logic            last_div, last_row;
    state_t          state;

`ifdef KEYSCAN_SYNC_EN
    logic [COLS-1:0] sync1, sync2;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= C;
            sync2 <= sync1;
        end
    assign col = sync2;
`else
    assign col = C;
`endif

    assign last_div = div == DW'(SCAN_DIV - 1);
    assign last_row = row == RW'(ROWS - 1);
    assign L        = ROWS'(1) << row;
    assign nxt_cnt  = (full != prev) ? '0 : (cnt == SW'(DEBOUNCE)) ? cnt : cnt + 1'b1;

    // frame being assembled, with the current row's columns merged in
    always_comb begin
        full = frame;
        full[int'(row) * COLS +: COLS] = col;
    end

    always_comb begin
        low = '0;
        for (int i = N - 1; i >= 0; i--)
            if (deb[i]) low = KW'(i);
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            div   <= '0;
            row   <= '0;
            frame <= '0;
            prev  <= '0;
            deb   <= '0;
            cnt   <= '0;
        end else begin
            div <= last_div ? '0 : div + 1'b1;
            if (last_div) begin
                row   <= last_row ? '0 : row + 1'b1;
                frame <= full;
                if (last_row) begin
                    prev <= full;
                    cnt  <= nxt_cnt;
                    if (nxt_cnt == SW'(DEBOUNCE)) deb <= full;
                end
            end
        end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            key_held <= |deb;
            case (state)
                IDLE: if (|deb) begin
                    state     <= REPORT;
                    key_valid <= 1'b1;
                    key_code  <= low;
                end
                REPORT: if (key_ready) begin
                    state     <= |deb ? HELD : IDLE;
                    key_valid <= 1'b0;
                end
                HELD: if (~|deb) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule
